bcd_scan_ctrl: RTL and testbench
================================

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, is the clock cycles each digit is held active; legal range 2..65535.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 count_en  input  1  advance the counter by one in a cycle where this is high.
REQ-005 clear  input  1  synchronous clear of the counter to 0000.
REQ-006 load  input  1  synchronous load of load_val into the counter.
REQ-007 load_val  input  16  four BCD nibbles, [3:0] = digit 0 (ones), [15:12] = digit 3.
REQ-008 digits  output  16  current counter value, BCD, same nibble order as load_val.
REQ-009 wrap  output  1  one-cycle pulse on 9999->0000 rollover.
REQ-010 load_err  output  1  one-cycle pulse when a load is rejected.
REQ-011 seg  output  7  shared segment bus, active-low, {g,f,e,d,c,b,a}.
REQ-012 an  output  4  digit enables, active-low, one-hot-zero.

Function
REQ-013 Counter is four cascaded BCD digits; digit n+1 increments only when digit n goes 9->0 in the same cycle.
REQ-014 Command priority: clear > load > count_en; one action per cycle.
REQ-015 load with every load_val nibble <= 9 sets digits = load_val next cycle.
REQ-016 load with any nibble > 9: digits unchanged, load_err = 1 for the next cycle only, count_en in that cycle ignored.
REQ-017 count_en at 9999 yields 0000 and wrap = 1 for the next cycle only; wrap is 0 at all other times.
REQ-018 clear or load in the same cycle as a would-be rollover suppresses wrap.
REQ-019 Prescaler counts 0..SCAN_DIV-1 and then returns to 0; when it returns to 0, the 2-bit scan index advances 0->1->2->3->0.
REQ-020 an = ~(4'b0001 << index); exactly one bit is low at any time after reset.
REQ-021 seg = segment pattern of digits[index]; codes 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
REQ-022 seg and an are registered and change in the same clock edge; seg reflects digits one cycle late (one-cycle latency from counter update to seg).
REQ-023 Scan runs freely and is unaffected by clear, load, count_en or load_err.
REQ-024 Counter changes mid-scan slot are shown on the next cycle without waiting for the slot to end.

Reset
REQ-025 n_rst low asynchronously forces digits = 0000, wrap = 0, load_err = 0, prescaler = 0, index = 0, an = 4'b1110, seg = 7'b1000000.
REQ-026 Reset asserted mid-operation discards pending commands; first update after release occurs on the first rising edge with n_rst high.

Configuration
REQ-027 Macro BCD_BLANK_LEADING_ZEROS_EN defined: for index 3..1, seg = 7'b1111111 when that digit and all higher digits are 0; digit 0 is never blanked.
REQ-028 Macro BCD_BLANK_LEADING_ZEROS_EN undefined: all four digits are always displayed, including leading zeros.
REQ-029 The macro shall not alter counter, wrap, load_err, an or scan timing.

Verification
REQ-030 Reset, then 4*SCAN_DIV idle cycles with SCAN_DIV=4 -> an sequence 1110,1101,1011,0111, each held 4 cycles; seg = 1000000 throughout (macro off).
REQ-031 load 0x0999, then one count_en -> digits = 0x1000, wrap stays 0; load 0x9999, then one count_en -> digits = 0x0000, wrap high exactly one cycle.
REQ-032 load_val = 0x12A4 with load -> digits unchanged, load_err high exactly one cycle; clear, load and count_en together -> digits = 0x0000.
REQ-033 digits = 0x0042, macro on -> index 3,2 seg = 1111111; index 1 seg = 0011001; index 0 seg = 0100100; macro off -> index 3,2 seg = 1000000.
REQ-034 Continuous count_en with n_rst pulsed low mid-count, between clock edges -> outputs reach REQ-025 values immediately; counting resumes from 0000 after release.

Source files
------------

// File: rtl/bcd_scan_ctrl_if.sv
// rtl/bcd_scan_ctrl_if.sv - command and display bundle for the BCD scan controller
// Purpose: groups the counter commands and the counter/display outputs.
// Signals:
//   count_en, clear, load, load_val : commands into the controller
//   digits, wrap, load_err          : counter state and one-cycle status pulses
//   seg, an                         : multiplexed active-low 7-segment drive
// Modports: master drives commands and observes outputs; slave is the controller.
interface bcd_scan_ctrl_if;
  logic        count_en;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        wrap;
  logic        load_err;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output count_en, clear, load, load_val,
    input  digits, wrap, load_err, seg, an
  );

  modport slave (
    input  count_en, clear, load, load_val,
    output digits, wrap, load_err, seg, an
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - four-digit BCD counter with multiplexed 7-segment scan
// Purpose: BCD up-counter (clear > load > count_en) driving a time-multiplexed
//   active-low display; the scan runs freely off a SCAN_DIV-cycle prescaler.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : bcd_scan_ctrl_if.slave (commands in; digits, wrap, load_err, seg, an out)
// Parameter: SCAN_DIV (2..65535) clock cycles each digit is held active.
// Option: define BCD_BLANK_LEADING_ZEROS_EN to blank leading zeros on digits 3..1.
module bcd_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic            clk,
  input  logic            n_rst,
  bcd_scan_ctrl_if.slave  bus
);

  logic [15:0] digits_q;
  logic        wrap_q;
  logic        load_err_q;
  logic [15:0] pre_q;
  logic [15:0] pre_next;
  logic [1:0]  idx_q;
  logic [1:0]  idx_next;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  logic [15:0] inc_val;
  logic        rollover;
  logic        carry;
  logic        load_ok;
  logic [3:0]  shown_digit;
  logic        blank;
  logic [6:0]  seg_next;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0011000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Ripple BCD increment: a digit advances only while every lower digit wraps 9->0.
  // A carry surviving all four digits means 9999 -> 0000.
  always_comb begin
    inc_val = digits_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digits_q[i*4 +: 4] == 4'd9) begin
          inc_val[i*4 +: 4] = 4'd0;
        end else begin
          inc_val[i*4 +: 4] = digits_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    rollover = carry;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.load_val[i*4 +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      digits_q   <= 16'h0000;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.clear) begin
        digits_q <= 16'h0000;
      end else if (bus.load) begin
        // A rejected load still consumes the cycle, so count_en is dropped.
        if (load_ok) digits_q <= bus.load_val;
        else         load_err_q <= 1'b1;
      end else if (bus.count_en) begin
        digits_q <= inc_val;
        wrap_q   <= rollover;
      end
    end
  end

  always_comb begin
    pre_next = pre_q + 16'd1;
    idx_next = idx_q;
    if (pre_q == 16'(SCAN_DIV - 1)) begin
      pre_next = 16'd0;
      idx_next = idx_q + 2'd1;
    end
  end

  // seg and an are both built from idx_next so they switch on the same edge;
  // seg samples the registered counter, hence one cycle behind a counter update.
  always_comb begin
    shown_digit = digits_q[idx_next*4 +: 4];
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    blank = ((idx_next == 2'd3) && (digits_q[15:12] == 4'd0)) ||
            ((idx_next == 2'd2) && (digits_q[15:8]  == 8'd0)) ||
            ((idx_next == 2'd1) && (digits_q[15:4]  == 12'd0));
`else
    blank = 1'b0;
`endif
    seg_next = blank ? 7'b1111111 : seg_code(shown_digit);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_q <= 16'd0;
      idx_q <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else begin
      pre_q <= pre_next;
      idx_q <= idx_next;
      an_q  <= ~(4'b0001 << idx_next);
      seg_q <= seg_next;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.seg      = seg_q;
  assign bus.an       = an_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - scoreboard bench for bcd_scan_ctrl with a decimal reference model
module tb_bcd_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0011000};

  logic clk;
  logic n_rst;
  bcd_scan_ctrl_if bus ();

  bcd_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic        wrap;
    logic        load_err;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   mval;      // counter value as a plain decimal integer
  int   ncyc;      // rising edges since reset release

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v = 0;
    for (int i = 0; i < 4; i++) v += int'(b[i*4 +: 4]) * pow10(i);
    return v;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] b);
    for (int i = 0; i < 4; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Display of digit position idx for a decimal value v.
  function automatic logic [6:0] seg_for(input int v, input int idx);
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    if (idx > 0 && v < pow10(idx)) return 7'b1111111;
`endif
    return SEG_TAB[(v / pow10(idx)) % 10];
  endfunction

  // One clock: apply commands, let the edge happen, push what the model predicts.
  task automatic step(input bit c, input bit l, input bit e, input logic [15:0] lv);
    exp_t x;
    int   prev;
    int   idx;
    bus.clear = c; bus.load = l; bus.count_en = e; bus.load_val = lv;
    @(posedge clk);
    prev = mval;
    x.wrap = 1'b0;
    x.load_err = 1'b0;
    if (c) mval = 0;
    else if (l) begin
      if (bcd_valid(lv)) mval = from_bcd(lv);
      else x.load_err = 1'b1;
    end else if (e) begin
      if (mval == 9999) x.wrap = 1'b1;
      mval = (mval + 1) % 10000;
    end
    ncyc++;
    idx = (ncyc / SCAN_DIV) % 4;
    x.digits = to_bcd(mval);
    x.an = ~(4'b0001 << idx);
    x.seg = seg_for(prev, idx);
    sb.push_back(x);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest prediction.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sb_digits", 32'(bus.digits), 32'(x.digits));
        chk("sb_wrap", 32'(bus.wrap), 32'(x.wrap));
        chk("sb_load_err", 32'(bus.load_err), 32'(x.load_err));
        chk("sb_an", 32'(bus.an), 32'(x.an));
        chk("sb_seg", 32'(bus.seg), 32'(x.seg));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_digits"}, 32'(bus.digits), 32'h0);
    chk({tag, "_wrap"}, 32'(bus.wrap), 32'h0);
    chk({tag, "_load_err"}, 32'(bus.load_err), 32'h0);
    chk({tag, "_an"}, 32'(bus.an), 32'(4'b1110));
    chk({tag, "_seg"}, 32'(bus.seg), 32'(7'b1000000));
  endtask

  initial begin
    logic [15:0] lv;
    logic [6:0]  seg_hi;
    int          sel;
    n_rst = 1'b0;
    bus.clear = 1'b0; bus.load = 1'b0; bus.count_en = 1'b0; bus.load_val = '0;
    mval = 0; ncyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Idle scan over four slots.
    repeat (4 * SCAN_DIV) step(0, 0, 0, 16'h0);

    // Carry across three digits, then rollover.
    step(0, 1, 0, 16'h0999);
    step(0, 0, 1, 16'h0);
    chk("carry_digits", 32'(bus.digits), 32'h1000);
    chk("carry_wrap", 32'(bus.wrap), 32'h0);
    step(0, 1, 0, 16'h9999);
    step(0, 0, 1, 16'h0);
    chk("roll_digits", 32'(bus.digits), 32'h0);
    chk("roll_wrap", 32'(bus.wrap), 32'h1);
    step(0, 0, 0, 16'h0);
    chk("roll_wrap_drop", 32'(bus.wrap), 32'h0);

    // Rejected load, with count_en in the same cycle.
    step(0, 1, 0, 16'h0357);
    step(0, 1, 1, 16'h12A4);
    chk("bad_load_digits", 32'(bus.digits), 32'h0357);
    chk("bad_load_err", 32'(bus.load_err), 32'h1);
    step(0, 0, 0, 16'h0);
    chk("bad_load_err_drop", 32'(bus.load_err), 32'h0);
    step(1, 1, 1, 16'h5555);
    chk("prio_clear", 32'(bus.digits), 32'h0);

    // Rollover suppressed by clear or load.
    step(0, 1, 0, 16'h9999);
    step(1, 0, 1, 16'h0);
    step(0, 1, 0, 16'h9999);
    step(0, 1, 1, 16'h0123);

    // Display of 0042 across all four slots.
    step(0, 1, 0, 16'h0042);
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    seg_hi = 7'b1111111;
`else
    seg_hi = 7'b1000000;
`endif
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      step(0, 0, 0, 16'h0);
      case (bus.an)
        4'b0111: chk("disp42_idx3", 32'(bus.seg), 32'(seg_hi));
        4'b1011: chk("disp42_idx2", 32'(bus.seg), 32'(seg_hi));
        4'b1101: chk("disp42_idx1", 32'(bus.seg), 32'(7'b0011001));
        4'b1110: chk("disp42_idx0", 32'(bus.seg), 32'(7'b0100100));
        default: chk("disp42_an_onehot", 32'(bus.an), 32'(4'b1110));
      endcase
    end

    // Randomized traffic biased toward rollover and invalid loads.
    for (int k = 0; k < 500; k++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: lv = 16'h9999;
        1: lv = 16'h9998;
        2: lv = 16'h0999;
        3: lv = to_bcd($urandom_range(0, 9999));
        default: lv = 16'($urandom);
      endcase
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, lv);
    end

    // Asynchronous reset in the middle of continuous counting.
    step(0, 1, 0, 16'h4567);
    repeat (7) step(0, 0, 1, 16'h0);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    sb.delete();
    mval = 0; ncyc = 0;
    @(negedge clk);
    #2;
    n_rst = 1'b1;
    step(0, 0, 1, 16'h0);
    chk("resume_digits", 32'(bus.digits), 32'h0001);
    repeat (3 * SCAN_DIV) step(0, 0, 1, 16'h0);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
